adc_sampler: RTL and testbench

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/adc_sampler.sv | 171 +++++++++++++++++
 tb/tb_adc_sampler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sampler.sv
// adc_sampler
//   Periodically triggers an external SPI ADC reader, collects 2^AVG_LOG2
//   12-bit samples, and publishes their average both as a raw code and as
//   millivolts against a 3.3 V reference. Missing slave-select edges,
//   triggers that arrive while a conversion is still in flight, and frames
//   with non-zero padding bits are recorded in sticky error flags.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           out  one-cycle start pulse to the SPI reader
//   ss_in        in   SPI reader slave-select, low while a transfer runs
//   data_rec     in   received frame: 4 zero MSBs + 12-bit ADC code
//   avg_code     out  averaged ADC code, held between valid pulses
//   mv           out  averaged voltage in millivolts, held between pulses
//   valid        out  one-cycle strobe when avg_code/mv update
//   err_timeout  out  sticky: an ss edge did not arrive within TIMEOUT clocks
//   err_overrun  out  sticky: a trigger arrived while not idle and was skipped
//   err_frame    out  sticky: a frame had non-zero bits [15:12]
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE      | waiting for the next period tick
// TRIG      | en is high this cycle; reader is being started
// WAIT_LOW  | waiting for ss_in to fall (transfer started)
// WAIT_HIGH | waiting for ss_in to rise (transfer finished)
// CAPTURE   | add the received code to the accumulator
// OUTPUT    | publish the average, pulse valid, clear the accumulator
`timescale 1ns/1ps
module adc_sampler #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned AVG_LOG2      = 3,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        en,
  input  logic        ss_in,
  input  logic [15:0] data_rec,
  output logic [11:0] avg_code,
  output logic [11:0] mv,
  output logic        valid,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        err_frame
);

  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] N_AVG   = CNT_W'(1 << AVG_LOG2);
  localparam logic [23:0]      VREF_MV = 24'd3300;

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_LOW, WAIT_HIGH, CAPTURE, OUTPUT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PER_W-1:0] r_per_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_ss_q;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en, r_valid;
  logic [11:0]      r_avg, r_mv;
  logic             r_err_to, r_err_ov, r_err_fr;

  logic             w_tick, w_to_hit, w_set_to, w_set_ov;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [11:0]      w_avg, w_mv;

  assign w_tick    = (r_per_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_avg     = r_acc[AVG_LOG2 +: 12];
  // 12-bit code times 3300 always fits in 24 bits; keep the integer part of /4096.
  assign w_mv      = 12'(({12'd0, w_avg} * VREF_MV) >> 12);

  always_comb begin
    w_state_nxt = r_state;
    w_set_to    = 1'b0;
    w_set_ov    = w_tick && (r_state != IDLE);
    case (r_state)
      IDLE:      if (w_tick) w_state_nxt = TRIG;
      TRIG:      w_state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (!ss_in) begin
          w_state_nxt = WAIT_HIGH;
        end else if (w_to_hit) begin
          w_state_nxt = IDLE;
          w_set_to    = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (ss_in && !r_ss_q) begin
          w_state_nxt = CAPTURE;
        end else if (w_to_hit) begin
          w_state_nxt = IDLE;
          w_set_to    = 1'b1;
        end
      end
      CAPTURE:   w_state_nxt = (w_cnt_inc == N_AVG) ? OUTPUT : IDLE;
      OUTPUT:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt <= '0;
      r_to_cnt  <= '0;
      r_ss_q    <= 1'b1;
      r_en      <= 1'b0;
      r_err_to  <= 1'b0;
      r_err_ov  <= 1'b0;
    end else begin
      r_per_cnt <= w_tick ? '0 : r_per_cnt + PER_W'(1);
      // Cleared on every state change; saturates so a long IDLE cannot wrap it.
      if (w_state_nxt != r_state) r_to_cnt <= '0;
      else if (!w_to_hit)         r_to_cnt <= r_to_cnt + TO_W'(1);
      r_ss_q    <= ss_in;
      r_en      <= (r_state == IDLE) && w_tick;
      r_err_to  <= r_err_to | w_set_to;
      r_err_ov  <= r_err_ov | w_set_ov;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_avg    <= '0;
      r_mv     <= '0;
      r_valid  <= 1'b0;
      r_err_fr <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        CAPTURE: begin
          r_acc <= r_acc + ACC_W'(data_rec[11:0]);
          r_cnt <= w_cnt_inc;
          if (data_rec[15:12] != 4'd0) r_err_fr <= 1'b1;
        end
        OUTPUT: begin
          r_avg   <= w_avg;
          r_mv    <= w_mv;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign en          = r_en;
  assign valid       = r_valid;
  assign avg_code    = r_avg;
  assign mv          = r_mv;
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ov;
  assign err_frame   = r_err_fr;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler
//   Drives adc_sampler as an SPI reader would and compares every observable
//   output against a reference average computed from the frames sent.
//   A second instance with a 64-clock period exercises trigger overrun.
`timescale 1ns/1ps
module tb_adc_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ss_in, en, valid, err_timeout, err_overrun, err_frame;
  logic [15:0] data_rec;
  logic [11:0] avg_code, mv;

  logic        rst_ov, ss_ov, en_ov, valid_ov, err_to_ov, err_ovr_ov, err_fr_ov;
  logic [15:0] data_ov;
  logic [11:0] avg_ov, mv_ov;

  adc_sampler u_dut (
    .clk(clk), .rst(rst), .en(en), .ss_in(ss_in), .data_rec(data_rec),
    .avg_code(avg_code), .mv(mv), .valid(valid),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_frame(err_frame)
  );

  adc_sampler #(.SAMPLE_PERIOD(64)) u_dut_ov (
    .clk(clk), .rst(rst_ov), .en(en_ov), .ss_in(ss_ov), .data_rec(data_ov),
    .avg_code(avg_ov), .mv(mv_ov), .valid(valid_ov),
    .err_timeout(err_to_ov), .err_overrun(err_ovr_ov), .err_frame(err_fr_ov)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: running sum of the 12-bit codes, published every 8 samples.
  int          m_sum, m_cnt;
  logic [11:0] m_avg, m_mv;
  logic        m_err_fr, m_err_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_avg = '0; m_mv = '0; m_err_fr = 1'b0; m_err_to = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] d, output bit exp_v);
    m_sum += int'(d[11:0]);
    m_cnt++;
    if (d[15:12] != 4'd0) m_err_fr = 1'b1;
    exp_v = 1'b0;
    if (m_cnt == 8) begin
      exp_v = 1'b1;
      m_avg = 12'(m_sum / 8);
      m_mv  = 12'((int'(m_avg) * 3300) / 4096);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic wait_en(output int waited);
    waited = -1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (en === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  // One SPI transfer answering a trigger, followed by checks against the model.
  task automatic run_frame(input logic [15:0] d, input bit en_seen, input string tag);
    int w, lead, low_len;
    logic [3:0] seen;
    bit exp_v;
    if (!en_seen) begin
      wait_en(w);
      chk($sformatf("%s_en_arrives", tag), w > 0, 1);
    end
    lead    = $urandom_range(2, 8);
    low_len = $urandom_range(6, 40);
    @(negedge clk);
    chk($sformatf("%s_en_one_cycle", tag), en, 0);
    repeat (lead - 1) @(negedge clk);
    data_rec = d;
    ss_in    = 1'b0;
    repeat (low_len) @(negedge clk);
    ss_in = 1'b1;
    seen  = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      seen[n] = valid;
    end
    model_push(d, exp_v);
    chk($sformatf("%s_valid_timing", tag), seen, exp_v ? 4'b0100 : 4'b0000);
    chk($sformatf("%s_avg_code", tag), avg_code, m_avg);
    chk($sformatf("%s_mv", tag), mv, m_mv);
    chk($sformatf("%s_err_frame", tag), err_frame, m_err_fr);
    chk($sformatf("%s_err_timeout", tag), err_timeout, m_err_to);
    chk($sformatf("%s_err_overrun", tag), err_overrun, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s_en", tag), en, 0);
    chk($sformatf("%s_valid", tag), valid, 0);
    chk($sformatf("%s_avg_code", tag), avg_code, 0);
    chk($sformatf("%s_mv", tag), mv, 0);
    chk($sformatf("%s_errs", tag), {err_timeout, err_overrun, err_frame}, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, first_i, en_bad, en_cnt;
    logic [15:0] d;

    rst = 1'b1; ss_in = 1'b1; data_rec = '0;
    rst_ov = 1'b1; ss_ov = 1'b1; data_ov = 16'h0800;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Mid-scale input
    for (int i = 0; i < 8; i++) run_frame(16'h0800, 1'b0, $sformatf("mid%0d", i));
    chk("mid_avg_const", avg_code, 2048);
    chk("mid_mv_const", mv, 1650);

    // Full scale, largest possible accumulator sum
    for (int i = 0; i < 8; i++) run_frame(16'h0FFF, 1'b0, $sformatf("full%0d", i));
    chk("full_avg_const", avg_code, 4095);
    chk("full_mv_const", mv, 3299);

    // Alternating extremes
    for (int i = 0; i < 8; i++)
      run_frame((i % 2) ? 16'h0FFF : 16'h0000, 1'b0, $sformatf("alt%0d", i));
    chk("alt_avg_const", avg_code, 2047);
    chk("alt_mv_const", mv, 1649);

    // Timeout in WAIT_LOW in the middle of a batch of random samples
    for (int i = 0; i < 3; i++) begin
      d = {4'h0, 12'($urandom_range(0, 4095))};
      run_frame(d, 1'b0, $sformatf("rnda%0d", i));
    end
    wait_en(w);
    chk("to_en_arrives", w > 0, 1);
    first_i = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        first_i = i;
        break;
      end
    end
    chk("to_after_64_clocks", first_i, 65);
    chk("to_no_valid", valid, 0);
    m_err_to = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = {4'h0, 12'($urandom_range(0, 4095))};
      run_frame(d, 1'b0, $sformatf("rndb%0d", i));
    end

    // Bad frame, then reset after 5 of 8 samples
    for (int i = 0; i < 5; i++) begin
      d = (i == 2) ? 16'hF123 : {4'h0, 12'($urandom_range(0, 4095))};
      run_frame(d, 1'b0, $sformatf("pre%0d", i));
    end
    chk("frame_err_set", err_frame, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_i = -1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (en === 1'b1) begin
        first_i = i;
        break;
      end
    end
    chk("post_reset_first_trigger", first_i, 1000);
    chk("post_reset_avg", avg_code, 0);
    chk("post_reset_errs", {err_timeout, err_overrun, err_frame}, 0);
    for (int i = 0; i < 8; i++) begin
      d = {4'h0, 12'($urandom_range(0, 4095))};
      run_frame(d, i == 0, $sformatf("post%0d", i));
    end

    // Overrun: 64-clock period, transfers longer than one period
    rst_ov = 1'b0;
    en_bad = 0;
    en_cnt = 0;
    for (int t = 0; t < 3; t++) begin
      w = -1;
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (en_ov === 1'b1) begin
          w = i;
          break;
        end
      end
      if (w > 0) en_cnt++;
      repeat (30) begin @(negedge clk); if (en_ov) en_bad++; end
      ss_ov = 1'b0;
      repeat (40) begin @(negedge clk); if (en_ov) en_bad++; end
      ss_ov = 1'b1;
      repeat (4) begin @(negedge clk); if (en_ov) en_bad++; end
    end
    chk("ov_triggers_seen", en_cnt, 3);
    chk("ov_no_en_during_xfer", en_bad, 0);
    chk("ov_flag", err_ovr_ov, 1);
    chk("ov_no_timeout", err_to_ov, 0);
    chk("ov_main_unaffected", err_overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
